// File: rtl/vga_box_animator_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_box_animator_if
//  Description : Pixel/sync bundle between a VGA sync generator, the box
//                animator and the DAC-side consumer.
//                master : drives counters, syncs, switches; observes RGB/LED
//                slave  : the animator (consumes counters, produces pixel)
//  Signals     : CounterX/CounterY [9:0] pixel column/line
//                InDisplayArea     visible-pixel flag
//                h_sync_in/v_sync_in active-low syncs from the generator
//                SW[3:0]           [1:0] speed, [2] pause, [3] invert
//                RED[2:0] GREEN[2:0] BLUE[1:0] registered RGB332 pixel
//                h_sync/v_sync     syncs aligned to RGB
//                LED[7:0]          bounce counter
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_box_animator_if;
    logic [9:0] CounterX;
    logic [9:0] CounterY;
    logic       InDisplayArea;
    logic       h_sync_in;
    logic       v_sync_in;
    logic [3:0] SW;
    logic [2:0] RED;
    logic [2:0] GREEN;
    logic [1:0] BLUE;
    logic       h_sync;
    logic       v_sync;
    logic [7:0] LED;

    modport master (
        output CounterX, CounterY, InDisplayArea, h_sync_in, v_sync_in, SW,
        input  RED, GREEN, BLUE, h_sync, v_sync, LED
    );

    modport slave (
        input  CounterX, CounterY, InDisplayArea, h_sync_in, v_sync_in, SW,
        output RED, GREEN, BLUE, h_sync, v_sync, LED
    );
endinterface
`default_nettype wire

// File: rtl/vga_box_animator.sv
`default_nettype none
// ============================================================================
//  Module      : vga_box_animator
//  Description : Draws a white BOX_W x BOX_H box that bounces around the
//                visible area, moving SW[1:0]+1 pixels per frame on each axis.
//                SW[2] pauses motion, SW[3] inverts visible pixels. LED counts
//                wall bounces (a corner hit counts twice).
//  Ports       : CLK_50 - sole clock, rising edge
//                RST    - asynchronous active-high reset
//                bus    - vga_box_animator_if.slave (counters, syncs,
//                         switches in; RGB332, delayed syncs, LED out)
//  Options     : VGA_FRAME_BORDER_EN - when defined, the outermost visible
//                rows/columns are drawn blue, overriding box and invert.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_box_animator #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX_W    = 64,
    parameter int BOX_H    = 48
) (
    input  logic              CLK_50,
    input  logic              RST,
    vga_box_animator_if.slave bus
);

    localparam logic [10:0] c_x_lim = 11'(H_ACTIVE - BOX_W);
    localparam logic [10:0] c_y_lim = 11'(V_ACTIVE - BOX_H);
    localparam logic [10:0] c_box_w = 11'(BOX_W);
    localparam logic [10:0] c_box_h = 11'(BOX_H);
    localparam logic [9:0]  c_v_end = 10'(V_ACTIVE);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        UPDATE_X   = 2'd1,
        UPDATE_Y   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_upd_x;
    logic        w_upd_y;

    logic [9:0]  r_box_x;
    logic [9:0]  r_box_y;
    logic        r_dir_x;      // 0 = right, 1 = left
    logic        r_dir_y;      // 0 = down,  1 = up
    logic [7:0]  r_led;
    logic        r_at_vend;

    logic        w_at_vend;
    logic        w_tick;
    logic [10:0] w_step;
    logic [10:0] w_x_mv;       // {flip, new position}
    logic [10:0] w_y_mv;

    logic        w_in_box;
    logic [7:0]  w_rgb;
    logic [7:0]  r_rgb;
    logic        r_hs;
    logic        r_vs;

    // One axis of motion: clamp to the wall and report a direction flip.
    // Sums are 11 bits so pos+step can never wrap past the limit test.
    function automatic logic [10:0] axis_move(
        input logic [9:0]  pos,
        input logic        dir_neg,
        input logic [10:0] step,
        input logic [10:0] lim
    );
        logic [10:0] sum;
        logic [10:0] res;
        sum = {1'b0, pos} + step;
        res = {1'b0, pos};
        if (!dir_neg) begin
            if (sum >= lim) res = {1'b1, lim[9:0]};
            else            res = {1'b0, sum[9:0]};
        end else begin
            if ({1'b0, pos} <= step) res = {1'b1, 10'd0};
            else                     res = {1'b0, pos - step[9:0]};
        end
        return res;
    endfunction

    // Frame tick: first cycle the line counter reaches V_ACTIVE.
    assign w_at_vend = (bus.CounterY == c_v_end);
    assign w_tick    = w_at_vend & ~r_at_vend;

    assign w_step = {9'd0, bus.SW[1:0]} + 11'd1;
    assign w_x_mv = axis_move(r_box_x, r_dir_x, w_step, c_x_lim);
    assign w_y_mv = axis_move(r_box_y, r_dir_y, w_step, c_y_lim);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) r_state <= WAIT_FRAME;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_upd_x     = 1'b0;
        w_upd_y     = 1'b0;
        case (r_state)
            WAIT_FRAME: begin
                if (w_tick && !bus.SW[2]) w_state_nxt = UPDATE_X;
            end
            UPDATE_X: begin
                w_upd_x     = 1'b1;
                w_state_nxt = UPDATE_Y;
            end
            UPDATE_Y: begin
                w_upd_y     = 1'b1;
                w_state_nxt = WAIT_FRAME;
            end
            default: w_state_nxt = WAIT_FRAME;
        endcase
    end

    // ------------------------------------------------- position and LED
    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            r_box_x   <= 10'd0;
            r_box_y   <= 10'd0;
            r_dir_x   <= 1'b0;
            r_dir_y   <= 1'b0;
            r_led     <= 8'd0;
            r_at_vend <= 1'b0;
        end else begin
            r_at_vend <= w_at_vend;
            if (w_upd_x) begin
                r_box_x <= w_x_mv[9:0];
                if (w_x_mv[10]) r_dir_x <= ~r_dir_x;
            end
            if (w_upd_y) begin
                r_box_y <= w_y_mv[9:0];
                if (w_y_mv[10]) r_dir_y <= ~r_dir_y;
            end
            // Update states are exclusive, so at most one flip per cycle.
            r_led <= r_led + {7'd0, (w_upd_x & w_x_mv[10]) | (w_upd_y & w_y_mv[10])};
        end
    end

    // ------------------------------------------------------- pixel path
    assign w_in_box = ({1'b0, bus.CounterX} >= {1'b0, r_box_x}) &&
                      ({1'b0, bus.CounterX} <  ({1'b0, r_box_x} + c_box_w)) &&
                      ({1'b0, bus.CounterY} >= {1'b0, r_box_y}) &&
                      ({1'b0, bus.CounterY} <  ({1'b0, r_box_y} + c_box_h));

`ifdef VGA_FRAME_BORDER_EN
    localparam logic [9:0] c_h_last = 10'(H_ACTIVE - 1);
    localparam logic [9:0] c_v_last = 10'(V_ACTIVE - 1);
    logic w_on_border;
    assign w_on_border = (bus.CounterX == 10'd0) || (bus.CounterX == c_h_last) ||
                         (bus.CounterY == 10'd0) || (bus.CounterY == c_v_last);
`endif

    always_comb begin
        w_rgb = 8'h00;
        if (bus.InDisplayArea) begin
            w_rgb = w_in_box ? 8'hFF : 8'h00;
            if (bus.SW[3]) w_rgb = ~w_rgb;
`ifdef VGA_FRAME_BORDER_EN
            if (w_on_border) w_rgb = 8'b000_000_11;
`endif
        end
    end

    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            r_rgb <= 8'h00;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
        end else begin
            r_rgb <= w_rgb;
            r_hs  <= bus.h_sync_in;
            r_vs  <= bus.v_sync_in;
        end
    end

    assign bus.RED    = r_rgb[7:5];
    assign bus.GREEN  = r_rgb[4:2];
    assign bus.BLUE   = r_rgb[1:0];
    assign bus.h_sync = r_hs;
    assign bus.v_sync = r_vs;
    assign bus.LED    = r_led;

endmodule
`default_nettype wire

// File: tb/tb_vga_box_animator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_box_animator
//  Description : Self-checking bench. A main 640x480 instance is checked every
//                cycle against a frame-level bouncing-box model; a 128x128
//                instance with a 32x32 box exercises the corner hit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_box_animator;

    localparam int HA = 640;
    localparam int VA = 480;
    localparam int BW = 64;
    localparam int BH = 48;
    localparam int CA = 128;
    localparam int CB = 32;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    vga_box_animator_if bus_m ();
    vga_box_animator_if bus_c ();

    vga_box_animator dut (
        .CLK_50 (clk),
        .RST    (rst),
        .bus    (bus_m)
    );

    vga_box_animator #(
        .H_ACTIVE (CA),
        .V_ACTIVE (CA),
        .BOX_W    (CB),
        .BOX_H    (CB)
    ) dut_c (
        .CLK_50 (clk),
        .RST    (rst),
        .bus    (bus_c)
    );

    int checks = 0;
    int errors = 0;

    // Frame-level model state: position, direction (+1/-1), bounce count.
    int mx, my, mdx, mdy, mled;
    int cx, cy, cdx, cdy, cled;
    logic [3:0] sw_cur;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic axis(inout int pos, inout int dir, input int lim,
                        input int step, inout int led);
        if (dir > 0) begin
            if (pos + step >= lim) begin pos = lim; dir = -1; led = (led + 1) % 256; end
            else pos = pos + step;
        end else begin
            if (pos <= step) begin pos = 0; dir = 1; led = (led + 1) % 256; end
            else pos = pos - step;
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mdx = 1; mdy = 1; mled = 0;
        cx = 0; cy = 0; cdx = 1; cdy = 1; cled = 0;
    endtask

    function automatic logic [7:0] exp_rgb(input int x, input int y, input logic ind,
                                           input logic inv, input int bx, input int by);
        logic [7:0] v;
        if (!ind) return 8'h00;
`ifdef VGA_FRAME_BORDER_EN
        if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) return 8'h03;
`endif
        v = (x >= bx && x < bx + BW && y >= by && y < by + BH) ? 8'hFF : 8'h00;
        if (inv) v = ~v;
        return v;
    endfunction

    // Per-cycle compare: outputs seen now must match the model applied to the
    // inputs that were present one clock earlier.
    bit         pend_valid = 1'b0;
    logic [7:0] pend_rgb;
    logic       pend_hs, pend_vs;

    always @(negedge clk) begin
        if (rst) begin
            pend_valid = 1'b0;
        end else begin
            if (pend_valid) begin
                chk("rgb", int'({bus_m.RED, bus_m.GREEN, bus_m.BLUE}), int'(pend_rgb));
                chk("h_sync", int'(bus_m.h_sync), int'(pend_hs));
                chk("v_sync", int'(bus_m.v_sync), int'(pend_vs));
            end
            pend_rgb   = exp_rgb(int'(bus_m.CounterX), int'(bus_m.CounterY),
                                 bus_m.InDisplayArea, bus_m.SW[3], mx, my);
            pend_hs    = bus_m.h_sync_in;
            pend_vs    = bus_m.v_sync_in;
            pend_valid = 1'b1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sw(input logic [3:0] s);
        sw_cur   = s;
        bus_m.SW = s;
        bus_c.SW = s;
    endtask

    task automatic drive(input int x, input int y, input logic ind,
                         input logic hs, input logic vs);
        bus_m.CounterX      = 10'(x);
        bus_m.CounterY      = 10'(y);
        bus_m.InDisplayArea = ind;
        bus_m.h_sync_in     = hs;
        bus_m.v_sync_in     = vs;
        bus_c.CounterX      = 10'(x % CA);
        bus_c.CounterY      = (y == VA) ? 10'(CA) : 10'(y % CA);
        bus_c.InDisplayArea = ind;
        bus_c.h_sync_in     = hs;
        bus_c.v_sync_in     = vs;
    endtask

    // Hold the line counter at V_ACTIVE long enough for both updates, then
    // advance the model by one frame and compare position and LED.
    task automatic frame_tick();
        int step;
        for (int i = 0; i < 4; i++) begin
            drive($urandom_range(0, 700), VA, 1'($urandom), 1'($urandom), 1'($urandom));
            cyc();
        end
        if (!sw_cur[2]) begin
            step = int'(sw_cur[1:0]) + 1;
            axis(mx, mdx, HA - BW, step, mled);
            axis(my, mdy, VA - BH, step, mled);
            axis(cx, cdx, CA - CB, step, cled);
            axis(cy, cdy, CA - CB, step, cled);
        end
        chk("box_x", int'(dut.r_box_x), mx);
        chk("box_y", int'(dut.r_box_y), my);
        chk("led", int'(bus_m.LED), mled);
        chk("corner_box_x", int'(dut_c.r_box_x), cx);
        chk("corner_led", int'(bus_c.LED), cled);
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        cyc();
    endtask

    task automatic pixel_cycle();
        int x, y;
        if ($urandom_range(0, 1) == 1) begin
            x = mx - 8 + int'($urandom_range(0, BW + 16));
            y = my - 8 + int'($urandom_range(0, BH + 16));
        end else begin
            x = int'($urandom_range(0, 700));
            y = int'($urandom_range(0, VA - 1));
        end
        if ($urandom_range(0, 15) == 0) x = HA - 1;
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        if (y > VA - 1) y = VA - 1;
        drive(x, y, $urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom));
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        set_sw(4'd0);
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        model_reset();
        #1;
        chk("reset_rgb", int'({bus_m.RED, bus_m.GREEN, bus_m.BLUE}), 0);
        chk("reset_hs", int'(bus_m.h_sync), 1);
        chk("reset_vs", int'(bus_m.v_sync), 1);
        chk("reset_led", int'(bus_m.LED), 0);
        repeat (3) cyc();
        rst = 1'b0;

        // Pixel decode against the box at its reset position (0,0).
        drive(10, 10, 1'b1, 1'b1, 1'b1); cyc();
        chk("in_box_white", int'({bus_m.RED, bus_m.GREEN, bus_m.BLUE}), 255);
        drive(64, 10, 1'b1, 1'b1, 1'b1); cyc();
        chk("right_edge_black", int'({bus_m.RED, bus_m.GREEN, bus_m.BLUE}), 0);
        set_sw(4'b1000);
        drive(64, 10, 1'b1, 1'b1, 1'b1); cyc();
        chk("invert_white", int'({bus_m.RED, bus_m.GREEN, bus_m.BLUE}), 255);
        drive(10, 10, 1'b0, 1'b1, 1'b1); cyc();
        chk("invert_blank_black", int'({bus_m.RED, bus_m.GREEN, bus_m.BLUE}), 0);
        set_sw(4'b0000);
        drive(0, 0, 1'b1, 1'b1, 1'b1); cyc();
`ifdef VGA_FRAME_BORDER_EN
        chk("border_corner", int'({bus_m.RED, bus_m.GREEN, bus_m.BLUE}), 3);
`else
        chk("border_corner", int'({bus_m.RED, bus_m.GREEN, bus_m.BLUE}), 255);
`endif
        drive(200, 200, 1'b1, 1'b0, 1'b1); cyc();
        chk("h_sync_delay", int'(bus_m.h_sync), 0);

        // One tick at speed 4, then a paused tick.
        set_sw(4'b0011);
        frame_tick();
        chk("tick_x_lit", int'(dut.r_box_x), 4);
        chk("tick_y_lit", int'(dut.r_box_y), 4);
        set_sw(4'b0111);
        frame_tick();
        chk("pause_x_lit", int'(dut.r_box_x), 4);
        chk("pause_y_lit", int'(dut.r_box_y), 4);

        // Reset while in UPDATE_X: the move is abandoned.
        set_sw(4'b0011);
        drive(5, VA, 1'b0, 1'b1, 1'b1);
        cyc();
        #2 rst = 1'b1;
        model_reset();
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        cyc(); cyc();
        rst = 1'b0;
        repeat (3) cyc();
        chk("abandon_x", int'(dut.r_box_x), 0);
        chk("abandon_y", int'(dut.r_box_y), 0);

        // Speed 4 from (0,0): Y reaches 432 at tick 108 (first bounce), X
        // reaches 576 at tick 144 (second bounce). The 128x128 instance hits
        // 96 on both axes at tick 24, counting two bounces in one frame.
        for (int i = 1; i <= 145; i++) begin
            frame_tick();
            if (i == 23)  chk("corner_led_pre", int'(bus_c.LED), 0);
            if (i == 24) begin
                chk("corner_led_hit", int'(bus_c.LED), 2);
                chk("corner_y_hit", int'(dut_c.r_box_y), 96);
            end
            if (i == 108) chk("y_bounce_led", int'(bus_m.LED), 1);
            if (i == 144) begin
                chk("x_clamp_lit", int'(dut.r_box_x), 576);
                chk("x_clamp_led", int'(bus_m.LED), 2);
            end
            if (i == 145) chk("x_return_lit", int'(dut.r_box_x), 572);
        end

        // Asynchronous reset mid-frame with non-reset outputs showing.
        drive(mx + 1, my + 1, 1'b1, 1'b0, 1'b0);
        cyc(); cyc();
        chk("pre_reset_rgb", int'({bus_m.RED, bus_m.GREEN, bus_m.BLUE}), 255);
        #3 rst = 1'b1;
        #1;
        chk("async_rgb", int'({bus_m.RED, bus_m.GREEN, bus_m.BLUE}), 0);
        chk("async_hs", int'(bus_m.h_sync), 1);
        chk("async_vs", int'(bus_m.v_sync), 1);
        chk("async_led", int'(bus_m.LED), 0);
        model_reset();
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // Randomised frames: switches, pixels and syncs all random.
        for (int f = 0; f < 80; f++) begin
            set_sw(4'($urandom));
            repeat ($urandom_range(10, 40)) pixel_cycle();
            frame_tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
